dmem_access_ctrl: RTL and testbench

- Sequences every data-memory transaction onto the single-port word-wide data RAM.
- The RAM has one write-enable bit and 1-cycle synchronous read latency.
- Arbitrates round-robin between two requesters: port 0 (CPU load/store unit) and port 1 (UART program/data loader).
- Converts byte and halfword stores into read-modify-write sequences, and extracts, sign-extends or zero-extends sub-word loads.

---
 rtl/dmem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: round-robin arbitration between two requesters onto a
// single-port RAM, with read-modify-write for sub-word stores and extension for sub-word loads.
module dmem_access_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       din_q, din_d;

  logic              sel;
  logic              req_we, req_uns, req_bad;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_val, merged;

  // Address bits above the RAM word range wrap and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m1_addr[31:ADDR_W+2]};

  always_comb begin
    sel       = m0_req && m1_req ? ~last_grant_q : m1_req;
    req_we    = sel ? m1_we       : m0_we;
    req_size  = sel ? m1_size     : m0_size;
    req_uns   = sel ? m1_unsigned : m0_unsigned;
    req_addr  = sel ? m1_addr     : m0_addr;
    req_wdata = sel ? m1_wdata    : m0_wdata;
    req_bad   = (req_size == 2'd3) ||
                (req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  end

  always_comb begin
    lane_b = ram_dout[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = ram_dout[15:8];
      2'd2:    lane_b = ram_dout[23:16];
      2'd3:    lane_b = ram_dout[31:24];
      default: lane_b = ram_dout[7:0];
    endcase
    lane_h = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'd0:    load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'd1:    load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = ram_dout;
    endcase
    // din_q still holds the right-aligned store data while the old word is being read.
    merged = ram_dout;
    if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd1:    merged[15:8]  = din_q[7:0];
        2'd2:    merged[23:16] = din_q[7:0];
        2'd3:    merged[31:24] = din_q[7:0];
        default: merged[7:0]   = din_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = din_q[15:0];
    end else begin
      merged[15:0] = din_q[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    addr_d       = addr_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    din_d        = din_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d      = sel;
          last_grant_d = sel;
          we_d         = req_we;
          size_d       = req_size;
          uns_d        = req_uns;
          addr_d       = req_addr[ADDR_W+1:0];
          din_d        = req_wdata;
          err_d        = req_bad;
          state_d      = req_bad ? DONE : ACCESS;
        end
      end
      ACCESS: state_d = (we_q && size_q == 2'd2) ? DONE : WAIT;
      WAIT: begin
        if (we_q) begin
          din_d   = merged;
          state_d = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      rdata_q      <= 32'd0;
      din_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      din_q        <= din_d;
    end
  end

  assign ram_we   = (state_q == ACCESS && we_q && size_q == 2'd2) || (state_q == WRITE);
  assign ram_addr = addr_q[ADDR_W+1:2];
  assign ram_din  = din_q;
  assign m0_ack   = (state_q == DONE) && !grant_q;
  assign m1_ack   = (state_q == DONE) && grant_q;
  assign busy     = (state_q != IDLE);
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed transactions push expected acks, a
// negedge monitor pops and compares them; a behavioural RAM model sits on the RAM port.
module tb_dmem_access_ctrl;

  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m0_unsigned, m0_ack;
  logic [1:0]        m0_size;
  logic [31:0]       m0_addr, m0_wdata;
  logic              m1_req, m1_we, m1_unsigned, m1_ack;
  logic [1:0]        m1_size;
  logic [31:0]       m1_addr, m1_wdata;
  logic [31:0]       rdata;
  logic              err, busy, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  typedef struct {
    int          port;
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        chk_lat;
    int          ack_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          we_count   = 0;
  int          last_we_cyc = -1;
  logic [31:0] last_rdata = 32'd0;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: every ack pops one expectation; RAM write cycles are tallied for the stimulus side.
  always @(negedge clk) begin
    exp_t e;
    if (ram_we) begin
      we_count++;
      last_we_cyc = cyc;
    end
    if (m0_ack && m1_ack) checkOutput("dual_ack", {m1_ack, m0_ack}, 32'd0);
    if (m0_ack || m1_ack) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_ack", {m1_ack, m0_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("ack_port", {31'd0, m1_ack}, e.port);
        checkOutput("ack_err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_rdata) checkOutput("ack_rdata", rdata, e.rdata);
        if (e.chk_lat)   checkOutput("ack_latency", cyc, e.ack_cyc);
      end
    end
  end

  task automatic drivePort(input int port, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      m0_we = we; m0_size = size; m0_unsigned = uns; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_size = size; m1_unsigned = uns; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end
  endtask

  function automatic exp_t makeExp(input int port, input logic we, input logic exp_err,
                                   input logic [31:0] load_val, input logic chk_lat, input int ack_cyc);
    exp_t e;
    e.port      = port;
    e.err       = exp_err;
    e.chk_rdata = !exp_err;
    e.rdata     = (we || exp_err) ? last_rdata : load_val;
    e.chk_lat   = chk_lat;
    e.ack_cyc   = ack_cyc;
    if (!we && !exp_err) last_rdata = load_val;
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns one negedge after the ack.
  task automatic applyStimulus(input int port, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] load_val, input int lat,
                               output int issued);
    int got = 0;
    issued = cyc;
    sb_q.push_back(makeExp(port, we, exp_err, load_val, 1'b1, cyc + lat));
    drivePort(port, we, size, uns, addr, wdata);
    for (int t = 0; t < 30 && got == 0; t++) begin
      @(negedge clk);
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) got = 1;
    end
    checkOutput("ack_seen", got, 1);
    if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int issued;
    int we0;
    int n0;
    int n1;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_size = 0; m0_unsigned = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_size = 0; m1_unsigned = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ram_we", {31'd0, ram_we}, 32'd0);
    checkOutput("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_ram_addr", {18'd0, ram_addr}, 32'd0);
    checkOutput("rst_ram_din", ram_din, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] word store then load");
    we0 = we_count;
    applyStimulus(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2, issued);
    checkOutput("sw_we_cycles", we_count - we0, 1);
    applyStimulus(0, 0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 3, issued);
    applyStimulus(0, 0, 2'd2, 0, 32'h0001_0010, 32'h0, 0, 32'hDEADBEEF, 3, issued);

    $display("[TB] byte read-modify-write");
    applyStimulus(0, 1, 2'd2, 0, 32'h20, 32'h11223344, 0, 32'h0, 2, issued);
    we0 = we_count;
    applyStimulus(0, 1, 2'd0, 0, 32'h22, 32'h000000AA, 0, 32'h0, 4, issued);
    checkOutput("sb_we_cycles", we_count - we0, 1);
    checkOutput("sb_we_in_write", last_we_cyc, issued + 3);
    applyStimulus(0, 0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h11AA3344, 3, issued);

    $display("[TB] sub-word loads");
    applyStimulus(0, 1, 2'd2, 0, 32'h30, 32'h80FF7F01, 0, 32'h0, 2, issued);
    applyStimulus(0, 0, 2'd0, 0, 32'h32, 32'h0, 0, 32'hFFFFFFFF, 3, issued);
    applyStimulus(0, 0, 2'd0, 1, 32'h32, 32'h0, 0, 32'h000000FF, 3, issued);
    applyStimulus(0, 0, 2'd1, 0, 32'h32, 32'h0, 0, 32'hFFFF80FF, 3, issued);
    applyStimulus(1, 0, 2'd1, 1, 32'h30, 32'h0, 0, 32'h00007F01, 3, issued);

    $display("[TB] error requests");
    we0 = we_count;
    applyStimulus(0, 0, 2'd2, 0, 32'h13, 32'h0, 1, 32'h0, 1, issued);
    applyStimulus(1, 1, 2'd1, 0, 32'h21, 32'h00001234, 1, 32'h0, 1, issued);
    applyStimulus(0, 1, 2'd3, 0, 32'h30, 32'hFFFFFFFF, 1, 32'h0, 1, issued);
    checkOutput("err_we_cycles", we_count - we0, 0);
    checkOutput("err_mem_0x10", mem[4], 32'hDEADBEEF);
    checkOutput("err_mem_0x20", mem[8], 32'h11AA3344);
    checkOutput("err_mem_0x30", mem[12], 32'h80FF7F01);

    $display("[TB] reset during read-modify-write");
    applyStimulus(0, 1, 2'd2, 0, 32'h40, 32'h55667788, 0, 32'h0, 2, issued);
    we0 = we_count;
    drivePort(0, 1, 2'd0, 0, 32'h41, 32'h00000099);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    checkOutput("rrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rrst_ram_we", {31'd0, ram_we}, 32'd0);
    checkOutput("rrst_ack", {31'd0, m0_ack}, 32'd0);
    rst = 1'b0;
    last_rdata = 32'd0;
    @(negedge clk);
    checkOutput("rrst_we_cycles", we_count - we0, 0);
    checkOutput("rrst_mem", mem[16], 32'h55667788);
    applyStimulus(0, 1, 2'd0, 0, 32'h41, 32'h00000099, 0, 32'h0, 4, issued);
    applyStimulus(0, 0, 2'd2, 0, 32'h40, 32'h0, 0, 32'h55669988, 3, issued);

    $display("[TB] saturated arbitration from reset");
    rst = 1'b1;
    last_rdata = 32'd0;
    drivePort(0, 0, 2'd2, 0, 32'h10, 32'h0);
    drivePort(1, 0, 2'd2, 0, 32'h20, 32'h0);
    sb_q.push_back(makeExp(0, 0, 0, 32'hDEADBEEF, 1'b0, 0));
    sb_q.push_back(makeExp(1, 0, 0, 32'h11AA3344, 1'b0, 0));
    sb_q.push_back(makeExp(0, 0, 0, 32'hDEADBEEF, 1'b0, 0));
    sb_q.push_back(makeExp(1, 0, 0, 32'h11AA3344, 1'b0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n0 = 0;
    n1 = 0;
    fork
      begin
        for (int t = 0; t < 100 && n0 < 2; t++) begin
          @(negedge clk);
          if (m0_ack) n0++;
        end
        m0_req = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && n1 < 2; t++) begin
          @(negedge clk);
          if (m1_ack) n1++;
        end
        m1_req = 1'b0;
      end
    join
    checkOutput("arb_m0_acks", n0, 2);
    checkOutput("arb_m1_acks", n1, 2);
    repeat (4) @(negedge clk);
    checkOutput("arb_extra_idle", {31'd0, busy}, 32'd0);
    checkOutput("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
